cache_line_mover: RTL and testbench

Memory-side burst engine for the data cache. When the cache controller FSM asserts writeback and/or load, it moves a full cache line between the data cache array and main memory, one word per memory handshake, and signals completion. It sits directly downstream of the cache controller FSM and directly upstream of the main-memory port.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/line_word_ctr.sv | 36 +++
 rtl/cache_line_mover.sv | 137 +++++++++++++
 tb/tb_cache_line_mover.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, sizes and address helpers for the cache line mover.
package cache_pkg;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned WORD_IDX_W     = $clog2(WORDS_PER_LINE);
  localparam int unsigned BYTE_OFF_W     = $clog2(DATA_W / 8);
  localparam int unsigned OFFSET_W       = WORD_IDX_W + BYTE_OFF_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } mover_state_t;

  localparam logic [ADDR_W-1:0] LINE_OFF_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  // Clear the byte-offset-within-line bits to get the line base address.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~LINE_OFF_MASK;
  endfunction

  // Word index of an address within its cache line.
  function automatic logic [WORD_IDX_W-1:0] word_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:BYTE_OFF_W];
  endfunction

endpackage

// File: rtl/line_word_ctr.sv
// Word index / beat counter for one line burst: loadable start index,
// wrapping word index, and a beat count that flags the last beat
// independently of where the word index started.
module line_word_ctr
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [WORD_IDX_W-1:0] i_start,
  input  logic                  i_adv,
  output logic [WORD_IDX_W-1:0] o_word_idx,
  output logic                  o_last
);

  logic [WORD_IDX_W-1:0] r_idx;
  logic [WORD_IDX_W-1:0] r_beat;

  // Load restarts a burst; each accepted beat advances both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_idx  <= i_start;
      r_beat <= '0;
    end else if (i_adv) begin
      r_idx  <= r_idx + WORD_IDX_W'(1);
      r_beat <= r_beat + WORD_IDX_W'(1);
    end
  end

  assign o_word_idx = r_idx;
  assign o_last     = (r_beat == WORD_IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_line_mover.sv
// Cache line burst engine between the cache controller and main memory.
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN (refill starts at the
// missing word and wraps; writeback always starts at word 0).
module cache_line_mover
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_writeback,
  input  logic                  req_load,
  input  logic [ADDR_W-1:0]     victim_addr,
  input  logic [ADDR_W-1:0]     line_addr,
  input  logic [DATA_W-1:0]     line_rdata,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic                  cache_we,
  output logic [DATA_W-1:0]     cache_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  done
);

  mover_state_t          r_state;
  mover_state_t          w_state_nxt;
  logic                  r_load_pend;
  logic [ADDR_W-1:0]     r_victim_addr;
  logic [ADDR_W-1:0]     r_line_addr;
  logic                  w_ctr_load;
  logic [WORD_IDX_W-1:0] w_ctr_start;
  logic                  w_ctr_adv;
  logic                  w_last;
  logic [WORD_IDX_W-1:0] w_crit_new;
  logic [WORD_IDX_W-1:0] w_crit_held;
  logic                  w_active;
  logic [ADDR_W-1:0]     w_base;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  // Refill starts at the missing word: straight from IDLE, or after a writeback.
  assign w_crit_new  = word_offset(line_addr);
  assign w_crit_held = word_offset(r_line_addr);
`else
  assign w_crit_new  = '0;
  assign w_crit_held = '0;
`endif

  line_word_ctr u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ctr_load),
    .i_start    (w_ctr_start),
    .i_adv      (w_ctr_adv),
    .o_word_idx (word_idx),
    .o_last     (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture: addresses and the pending-refill flag are taken in IDLE only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_pend   <= 1'b0;
      r_victim_addr <= '0;
      r_line_addr   <= '0;
    end else if (r_state == IDLE && req_writeback) begin
      r_load_pend   <= req_load;
      r_victim_addr <= victim_addr;
      r_line_addr   <= line_addr;
    end else if (r_state == IDLE && req_load) begin
      r_line_addr   <= line_addr;
    end else if (r_state == DONE) begin
      r_load_pend   <= 1'b0;
    end
  end

  // Next state and counter control; every ack moves one word.
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_load  = 1'b0;
    w_ctr_start = '0;
    w_ctr_adv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_writeback) begin
          w_state_nxt = WB;
          w_ctr_load  = 1'b1;
        end else if (req_load) begin
          w_state_nxt = REFILL;
          w_ctr_load  = 1'b1;
          w_ctr_start = w_crit_new;
        end
      end
      WB: begin
        if (mem_ack) begin
          w_ctr_adv = 1'b1;
          if (w_last) begin
            if (r_load_pend) begin
              w_state_nxt = REFILL;
              w_ctr_load  = 1'b1;
              w_ctr_start = w_crit_held;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end
      end
      REFILL: begin
        if (mem_ack) begin
          w_ctr_adv = 1'b1;
          if (w_last) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-side and cache-side outputs, decoded from state and counter.
  assign w_active    = (r_state == WB) || (r_state == REFILL);
  assign w_base      = (r_state == WB) ? line_base(r_victim_addr) : line_base(r_line_addr);
  assign mem_req     = w_active;
  assign mem_we      = (r_state == WB);
  assign mem_addr    = w_active ? (w_base + (ADDR_W'(word_idx) << BYTE_OFF_W)) : '0;
  assign mem_wdata   = (r_state == WB) ? line_rdata : '0;
  assign cache_we    = (r_state == REFILL) && mem_ack;
  assign cache_wdata = mem_rdata;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_cache_line_mover.sv
// Bench for cache_line_mover: transaction-level model plus directed scenarios
// and a randomized request/ack phase.
module tb_cache_line_mover;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_writeback = 1'b0;
  logic        req_load = 1'b0;
  logic [31:0] victim_addr = '0;
  logic [31:0] line_addr = '0;
  logic [31:0] line_rdata;
  logic [1:0]  word_idx;
  logic        cache_we;
  logic [31:0] cache_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] noise = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       q[$];
  logic        m_done = 1'b0;
  logic [31:0] cache_arr[4];
  logic [31:0] exp_a[8];
  logic [31:0] got_a[16];

  always #5 clk = ~clk;

  cache_line_mover dut (
    .clk(clk), .rst_n(rst_n), .req_writeback(req_writeback), .req_load(req_load),
    .victim_addr(victim_addr), .line_addr(line_addr), .line_rdata(line_rdata),
    .word_idx(word_idx), .cache_we(cache_we), .cache_wdata(cache_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Simple memory and cache array behind the mover.
  assign mem_rdata  = mem_ack ? mem_fn(mem_addr) : noise;
  assign line_rdata = cache_arr[word_idx];
  always @(posedge clk) if (cache_we) cache_arr[word_idx] <= cache_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a request becomes a list of memory beats, consumed one per ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (q.size() != 0) begin
      if (mem_ack) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (req_writeback || req_load) begin
      logic [31:0] vb, lb;
      int          st;
      vb = victim_addr & ~32'hF;
      lb = line_addr & ~32'hF;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      st = int'(line_addr[3:2]);
`else
      st = 0;
`endif
      if (req_writeback)
        for (int i = 0; i < 4; i++) q.push_back('{1'b1, vb + 32'(i * 4), cache_arr[i]});
      if (req_load)
        for (int i = 0; i < 4; i++) begin
          logic [31:0] a;
          a = lb + 32'(((st + i) % 4) * 4);
          q.push_back('{1'b0, a, mem_fn(a)});
        end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      beat_t e;
      e = q[0];
      chk("mem_req", mem_req, 1);
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("mem_we", mem_we, e.we);
      chk("mem_addr", mem_addr, e.addr);
      chk("word_idx", word_idx, e.addr[3:2]);
      if (e.we) chk("mem_wdata", mem_wdata, e.data);
      chk("cache_we", cache_we, !e.we && mem_ack);
      if (!e.we && mem_ack) chk("cache_wdata", cache_wdata, e.data);
    end else begin
      chk("idle_mem_req", mem_req, 0);
      chk("idle_busy", busy, m_done);
      chk("idle_done", done, m_done);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_cache_we", cache_we, 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_wdata", mem_wdata, 0);
    end
  end

  // Directed transfer: holds the request until done, stalls n cycles on write word 2.
  task automatic run_txn(input string nm, input logic wb, input logic ld,
                         input logic [31:0] va, input logic [31:0] la,
                         input int stall_n, input int exp_lat, input int n_exp);
    int cyc, n_got, n_cwe, stalls, extra;
    logic seen;
    @(posedge clk); #1;
    req_writeback = wb; req_load = ld; victim_addr = va; line_addr = la; mem_ack = 1'b0;
    cyc = 0; n_got = 0; n_cwe = 0; stalls = stall_n; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req && mem_we && word_idx == 2'd2 && stalls > 0) begin
        mem_ack = 1'b0;
        stalls--;
      end else begin
        mem_ack = 1'b1;
      end
      #1;
      if (mem_req && mem_ack && n_got < 16) begin
        got_a[n_got] = mem_addr;
        n_got++;
      end
      if (cache_we) n_cwe++;
      if (done) begin
        seen = 1'b1;
        req_writeback = 1'b0;
        req_load = 1'b0;
      end
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, "_beats"}, 32'(n_got), 32'(n_exp));
    chk({nm, "_cache_we_pulses"}, 32'(n_cwe), ld ? 32'd4 : 32'd0);
    for (int i = 0; i < n_exp && i < n_got; i++) chk({nm, "_addr"}, got_a[i], exp_a[i]);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (done) extra++;
    end
    chk({nm, "_extra_done"}, 32'(extra), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cache_arr[i] = $urandom;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_mem_addr", mem_addr, 0);
    #22 rst_n = 1'b1;

    // Refill only from 0x1000.
    for (int i = 0; i < 4; i++) exp_a[i] = 32'h1000 + 32'(i * 4);
    run_txn("refill", 1'b0, 1'b1, 32'h0, 32'h1000, 0, 5, 4);

    // Writeback of 0x2040 followed by refill of 0x3000.
    for (int i = 0; i < 4; i++) begin
      exp_a[i]     = 32'h2040 + 32'(i * 4);
      exp_a[i + 4] = 32'h3000 + 32'(i * 4);
    end
    run_txn("wb_refill", 1'b1, 1'b1, 32'h2040, 32'h3000, 0, 9, 8);

    // Writeback with three wait states on word 2.
    for (int i = 0; i < 4; i++) exp_a[i] = 32'h2040 + 32'(i * 4);
    run_txn("wb_stall", 1'b1, 1'b0, 32'h2040, 32'h0, 3, 8, 4);

    // Refill of a miss at 0x1008.
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    exp_a[0] = 32'h1008; exp_a[1] = 32'h100C; exp_a[2] = 32'h1000; exp_a[3] = 32'h1004;
`else
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1004; exp_a[2] = 32'h1008; exp_a[3] = 32'h100C;
`endif
    run_txn("crit_word", 1'b0, 1'b1, 32'h0, 32'h1008, 0, 5, 4);

    // Reset during the second refill beat.
    @(posedge clk); #1;
    req_load = 1'b1; line_addr = 32'h1000; mem_ack = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    req_load = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cache_we", cache_we, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_word_idx", word_idx, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_a[i] = 32'h1000 + 32'(i * 4);
    run_txn("after_reset", 1'b0, 1'b1, 32'h0, 32'h1000, 0, 5, 4);

    // Random requests, addresses and ack gaps, including requests while busy.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_writeback = ($urandom_range(0, 3) == 0);
      req_load      = ($urandom_range(0, 2) == 0);
      victim_addr   = $urandom;
      line_addr     = $urandom;
      mem_ack       = ($urandom_range(0, 3) != 0);
      noise         = $urandom;
    end
    @(posedge clk); #1;
    req_writeback = 1'b0; req_load = 1'b0; mem_ack = 1'b1;
    for (int c = 0; c < 40 && busy; c++) begin
      @(posedge clk); #1;
    end
    chk("drain_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
